// File: rtl/riscv_pkg.sv
// Shared front-end definitions: fetch FSM states and the sequential PC step.
package riscv_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/flush and an occupancy count.
// The caller guarantees no push when full unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;

  // NOTE: every signal gets its default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited sequential requests into an in-order buffer,
// with redirect flush and a DRAIN state that swallows responses to stale requests.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_valid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             misalign
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   sum_t;

  localparam sum_t DEPTH_C = sum_t'(DEPTH);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  cnt_t             in_flight_q, in_flight_d;
  cnt_t             discard_q, discard_d;
  logic             misalign_q, misalign_d;

  cnt_t             occupancy;
  sum_t             pending;
  logic             issue, push, pop, has_data;
  logic [WIDTH-1:0] resp_pc;
  logic [2*WIDTH-1:0] head;

  assign pending = {1'b0, occupancy} + {1'b0, in_flight_q};
  // rst gates the request so nothing issues while reset is held.
  assign issue   = rst && (state_q == RUN) && !redirect_valid && (pending < DEPTH_C);

  // In RUN all outstanding requests are consecutive and end just below fetch_pc.
  assign resp_pc = fetch_pc_q - WIDTH'(in_flight_q) * WIDTH'(PC_INCR);

  assign push     = imem_valid && (state_q == RUN) && !redirect_valid;
  assign has_data = (occupancy != '0);
  assign pop      = instr_valid && instr_ready;

  sync_fifo #(
    .WIDTH (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_ibuf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({imem_rdata, resp_pc}),
    .pop       (pop),
    .flush     (redirect_valid),
    .pop_data  (head),
    .count     (occupancy)
  );

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    in_flight_d = in_flight_q;
    discard_d   = discard_q;
    misalign_d  = redirect_valid && (redirect_pc[1:0] != 2'b00);

    case ({issue, imem_valid})
      2'b10:   in_flight_d = in_flight_q + cnt_t'(1);
      2'b01:   in_flight_d = in_flight_q - cnt_t'(1);
      default: in_flight_d = in_flight_q;
    endcase

    if (issue) fetch_pc_d = fetch_pc_q + WIDTH'(PC_INCR);

    if (state_q == DRAIN) begin
      if (imem_valid) discard_d = discard_q - cnt_t'(1);
      if (discard_d == '0) state_d = RUN;
    end

    // Redirect wins; a redirect while draining only retargets the PC.
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[WIDTH-1:2], 2'b00};
      if (state_q == RUN) begin
        discard_d = in_flight_d;
        state_d   = (in_flight_d != '0) ? DRAIN : RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      fetch_pc_q  <= RESET_PC;
      in_flight_q <= '0;
      discard_q   <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      in_flight_q <= in_flight_d;
      discard_q   <= discard_d;
      misalign_q  <= misalign_d;
    end
  end

  assign imem_req    = issue;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = has_data && !redirect_valid;
  assign instr       = has_data ? head[2*WIDTH-1:WIDTH] : '0;
  assign instr_pc    = has_data ? head[WIDTH-1:0] : '0;
  assign misalign    = misalign_q;

endmodule
